// File: rtl/code_convert_sequencer.sv
// Converts a packed 2421 word to excess-3 one digit per cycle through an external shared converter.
// Optional invalid-code checking is built when CODE_CONVERT_SEQ_CHECK_EN is defined.
module code_convert_sequencer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   in_2421,
    output logic [3:0]            conv_in,
    input  logic [3:0]            conv_out,
    output logic [4*DIGITS-1:0]   out_ex3,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int             IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0]  LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          idx_nxt;
    logic [4*DIGITS-1:0]    word_q;
    logic [4*DIGITS-1:0]    out_q;
    logic [3:0]             conv_in_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;
    logic [3:0]             store_d;
    logic                   err_d;

    assign idx_nxt = idx_q + 1'b1;

`ifdef CODE_CONVERT_SEQ_CHECK_EN
    logic bad_d;

    // Codes 0101..1010 have no 2421 meaning; mark them and force the digit to all ones.
    always_comb begin
        bad_d   = (conv_in_q >= 4'b0101) && (conv_in_q <= 4'b1010);
        store_d = bad_d ? 4'b1111 : conv_out;
        err_d   = err_q | bad_d;
    end
`else
    always_comb begin
        store_d = conv_out;
        err_d   = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            out_q     <= '0;
            conv_in_q <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        word_q    <= in_2421;
                        out_q     <= '0;
                        err_q     <= 1'b0;
                        idx_q     <= '0;
                        conv_in_q <= in_2421[3:0];
                        busy_q    <= 1'b1;
                        state_q   <= CONV;
                    end
                end
                CONV: begin
                    out_q[{idx_q, 2'b00} +: 4] <= store_d;
                    err_q                      <= err_d;
                    // conv_in is registered, so the next digit is presented one edge ahead.
                    if (idx_q == LAST) begin
                        conv_in_q <= 4'b0000;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        idx_q     <= idx_nxt;
                        conv_in_q <= word_q[{idx_nxt, 2'b00} +: 4];
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign conv_in = conv_in_q;
    assign out_ex3 = out_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_code_convert_sequencer.sv
// Randomized and directed bench for code_convert_sequencer with a decimal-level reference model.
module tb_code_convert_sequencer;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  in_2421;
    logic [3:0]    conv_in;
    logic [3:0]    conv_out;
    logic [W-1:0]  out_ex3;
    logic          busy;
    logic          done;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    code_convert_sequencer #(.DIGITS(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_2421  (in_2421),
        .conv_in  (conv_in),
        .conv_out (conv_out),
        .out_ex3  (out_ex3),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    function automatic bit is_valid(input logic [3:0] c);
        return (c <= 4'd4) || (c >= 4'd11);
    endfunction

    // Decimal value from the 2421 weights.
    function automatic logic [3:0] dec_of(input logic [3:0] c);
        int s;
        s = 2 * int'(c[3]) + 4 * int'(c[2]) + 2 * int'(c[1]) + int'(c[0]);
        return 4'(s);
    endfunction

    function automatic logic [3:0] enc_2421(input int d);
        return (d < 5) ? 4'(d) : 4'(d + 6);
    endfunction

    // Stand-in for the shared converter; invalid codes map to an arbitrary but fixed value.
    always_comb begin
        if (is_valid(conv_in)) conv_out = 4'(dec_of(conv_in) + 4'd3);
        else                   conv_out = conv_in ^ 4'h6;
    end

    function automatic logic [W-1:0] model_out(input logic [W-1:0] w);
        logic [W-1:0] r;
        logic [3:0]   c;
        r = '0;
        for (int i = 0; i < D; i++) begin
            c = w[4*i +: 4];
            if (is_valid(c)) r[4*i +: 4] = 4'(dec_of(c) + 4'd3);
`ifdef CODE_CONVERT_SEQ_CHECK_EN
            else             r[4*i +: 4] = 4'hF;
`else
            else             r[4*i +: 4] = c ^ 4'h6;
`endif
        end
        return r;
    endfunction

    function automatic logic model_err(input logic [W-1:0] w);
        logic e;
        e = 1'b0;
`ifdef CODE_CONVERT_SEQ_CHECK_EN
        for (int i = 0; i < D; i++) if (!is_valid(w[4*i +: 4])) e = 1'b1;
`endif
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion; lat is the cycle in which done was seen (0 if never).
    task automatic convert(input logic [W-1:0] w, input bit toggle,
                           output logic [W-1:0] o, output logic e, output int lat);
        in_2421 = w;
        start   = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        for (int c = 1; c <= D + 4; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            if (toggle) in_2421 = W'($urandom);
            tick();
        end
        o = out_ex3;
        e = err;
        tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; in_2421 = '0;
        tick(); tick();
        n_vec++;
        if ({out_ex3, err, busy, done, conv_in} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got out=%h err=%b busy=%b done=%b conv_in=%b, want all 0",
                     out_ex3, err, busy, done, conv_in);
        end
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if ({out_ex3, err, busy, done, conv_in} !== '0) begin
                n_err++;
                $display("FAIL idle_state c%0d: got out=%h err=%b busy=%b done=%b conv_in=%b, want all 0",
                         c, out_ex3, err, busy, done, conv_in);
            end
        end
    endtask

    task automatic test_example;
        logic [W-1:0] w;
        logic [W-1:0] want;
        w    = 16'hFB40;
        want = 16'hC873;
        in_2421 = w; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= D; c++) begin
            n_vec++;
            if (conv_in !== w[4*(c-1) +: 4] || busy !== 1'b1 || done !== 1'b0) begin
                n_err++;
                $display("FAIL example_conv_in c%0d: got conv_in=%b busy=%b done=%b, want %b 1 0",
                         c, conv_in, busy, done, w[4*(c-1) +: 4]);
            end
            if (c >= 2) begin
                n_vec++;
                if (out_ex3[4*(c-2) +: 4] !== want[4*(c-2) +: 4]) begin
                    n_err++;
                    $display("FAIL example_digit%0d: got %b, want %b", c - 2,
                             out_ex3[4*(c-2) +: 4], want[4*(c-2) +: 4]);
                end
            end
            tick();
        end
        n_vec++;
        if (done !== 1'b1 || out_ex3 !== want || err !== 1'b0 || conv_in !== 4'b0000) begin
            n_err++;
            $display("FAIL example_done: got done=%b out=%h err=%b conv_in=%b, want 1 %h 0 0000",
                     done, out_ex3, err, conv_in, want);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0 || out_ex3 !== want) begin
            n_err++;
            $display("FAIL example_after: got done=%b busy=%b out=%h, want 0 0 %h", done, busy, out_ex3, want);
        end
    endtask

    task automatic test_all_valid;
        logic [W-1:0] w, o, want;
        logic e;
        int lat, d;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < D; i++) begin
                d = (4 * k + i) % 10;
                w[4*i +: 4]    = enc_2421(d);
                want[4*i +: 4] = 4'(d + 3);
            end
            convert(w, 1'b0, o, e, lat);
            n_vec++;
            if (o !== want || e !== 1'b0 || lat != D + 1) begin
                n_err++;
                $display("FAIL all_valid w%0d: got out=%h err=%b lat=%0d, want %h 0 %0d", k, o, e, lat, want, D + 1);
            end
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL all_valid_single_done w%0d: got done=%b busy=%b, want 0 0", k, done, busy);
            end
        end
    endtask

    task automatic test_invalid;
        logic [W-1:0] o, want;
        logic e, want_e;
        int lat;
`ifdef CODE_CONVERT_SEQ_CHECK_EN
        want = 16'h3F45; want_e = 1'b1;
`else
        want = 16'h3345; want_e = 1'b0;
`endif
        convert(16'h0512, 1'b0, o, e, lat);
        n_vec++;
        if (o !== want || e !== want_e || lat != D + 1) begin
            n_err++;
            $display("FAIL invalid_word: got out=%h err=%b lat=%0d, want %h %b %0d", o, e, lat, want, want_e, D + 1);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] w, o;
        logic e;
        int lat;
        for (int k = 0; k < 24; k++) begin
            w = W'($urandom);
            if (k % 3 == 0) for (int i = 0; i < D; i++) w[4*i +: 4] = enc_2421(int'($urandom_range(0, 9)));
            convert(w, (k % 2) == 1, o, e, lat);
            n_vec++;
            if (o !== model_out(w) || e !== model_err(w) || lat != D + 1) begin
                n_err++;
                $display("FAIL random w%0d in=%h: got out=%h err=%b lat=%0d, want %h %b %0d",
                         k, w, o, e, lat, model_out(w), model_err(w), D + 1);
            end
        end
    endtask

    task automatic test_start_held;
        logic [W-1:0] latched;
        int seen;
        seen    = 0;
        latched = W'($urandom);
        in_2421 = latched;
        start   = 1'b1;
        for (int c = 1; c <= 3 * (D + 2); c++) begin
            tick();
            if (done) begin
                n_vec++;
                if (c != (D + 1) + seen * (D + 2) || out_ex3 !== model_out(latched) || err !== model_err(latched)) begin
                    n_err++;
                    $display("FAIL start_held pulse%0d: got cycle=%0d out=%h err=%b, want %0d %h %b", seen, c,
                             out_ex3, err, (D + 1) + seen * (D + 2), model_out(latched), model_err(latched));
                end
                seen++;
            end else if (!busy) begin
                latched = W'($urandom);
                in_2421 = latched;
            end else begin
                in_2421 = W'($urandom);
            end
        end
        start = 1'b0;
        n_vec++;
        if (seen != 3) begin
            n_err++;
            $display("FAIL start_held_count: got %0d done pulses, want 3", seen);
        end
        tick(); tick();
    endtask

    task automatic test_reset_abort;
        logic [W-1:0] w, o;
        logic e;
        int lat;
        bit dseen;
        w = W'($urandom);
        in_2421 = w; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (out_ex3 !== '0 || busy !== 1'b0 || done !== 1'b0 || conv_in !== 4'b0000 || err !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state: got out=%h busy=%b done=%b conv_in=%b err=%b, want all 0",
                     out_ex3, busy, done, conv_in, err);
        end
        dseen = 1'b0;
        for (int c = 0; c < D + 3; c++) begin
            tick();
            if (done || busy) dseen = 1'b1;
        end
        n_vec++;
        if (dseen) begin
            n_err++;
            $display("FAIL abort_no_done: got done/busy activity after abort, want none");
        end
        w = W'($urandom);
        convert(w, 1'b0, o, e, lat);
        n_vec++;
        if (o !== model_out(w) || e !== model_err(w) || lat != D + 1) begin
            n_err++;
            $display("FAIL abort_restart: got out=%h err=%b lat=%0d, want %h %b %0d",
                     o, e, lat, model_out(w), model_err(w), D + 1);
        end
    endtask

    initial begin
        test_reset();
        test_example();
        test_all_valid();
        test_invalid();
        test_random();
        test_start_held();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
